// File: rtl/dw03_updn_mod_ctr.sv
// Up/down modulo counter with programmable bound M, variable step and a
// choice of wrap-around or saturation at the bounds.
module dw03_updn_mod_ctr #(
    parameter int width      = 12,
    parameter int step_width = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  load,
    input  logic [width-1:0]      data,
    input  logic                  cen,
    input  logic                  up_dn,
    input  logic [step_width-1:0] step,
    input  logic [width-1:0]      modulus,
    input  logic                  sat_mode,
    output logic [width-1:0]      count,
    output logic                  tercnt,
    output logic                  wrap,
    output logic                  sat_hit
);

    // A step larger than the full range would wrap more than once; limit it to M+1.
    function automatic logic [width:0] clamp_step(input logic [step_width-1:0] st,
                                                  input logic [width:0]        m1);
        logic [width:0] s;
        s = {{(width + 1 - step_width){1'b0}}, st};
        return (s > m1) ? m1 : s;
    endfunction

    logic [width:0]   m_ext;
    logic [width:0]   m1;
    logic [width:0]   cnt_ext;
    logic [width:0]   s_eff;
    logic [width:0]   sum;
    logic [width-1:0] next_count;
    logic             next_wrap;
    logic             next_sat;

    always_comb begin
        m_ext      = {1'b0, modulus};
        m1         = m_ext + 1'b1;
        cnt_ext    = {1'b0, count};
        s_eff      = clamp_step(step, m1);
        sum        = cnt_ext + s_eff;
        next_count = count;
        next_wrap  = 1'b0;
        next_sat   = 1'b0;
        if (cen && (s_eff != '0)) begin
            if (up_dn) begin
                if (cnt_ext > m_ext) begin
                    // Out-of-range count re-enters at the bound it just passed.
                    if (sat_mode) begin
                        next_count = modulus;
                        next_sat   = 1'b1;
                    end else begin
                        next_count = '0;
                        next_wrap  = 1'b1;
                    end
                end else if (sum <= m_ext) begin
                    next_count = width'(sum);
                end else if (sat_mode) begin
                    next_count = modulus;
                    next_sat   = (count != modulus);
                end else begin
                    next_count = width'(sum - m1);
                    next_wrap  = 1'b1;
                end
            end else begin
                if (cnt_ext > m_ext) begin
                    next_count = modulus;
                end else if (s_eff <= cnt_ext) begin
                    next_count = width'(cnt_ext - s_eff);
                end else if (sat_mode) begin
                    next_count = '0;
                    next_sat   = (count != '0);
                end else begin
                    next_count = width'(cnt_ext + m1 - s_eff);
                    next_wrap  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            wrap    <= 1'b0;
            sat_hit <= 1'b0;
        end else if (clr) begin
            count   <= '0;
            wrap    <= 1'b0;
            sat_hit <= 1'b0;
        end else if (!load) begin
            count   <= data;
            wrap    <= 1'b0;
            sat_hit <= 1'b0;
        end else begin
            count   <= next_count;
            wrap    <= next_wrap;
            sat_hit <= next_sat;
        end
    end

    assign tercnt = up_dn ? (count == modulus) : (count == '0);

endmodule

// File: doc/dw03_updn_mod_ctr.md
DW03_UPDN_MOD_CTR -- requirements
Module: dw03_updn_mod_ctr

Interface
REQ-001 SHALL have parameter: width, 12, counter and bound width (2..32).
REQ-002 SHALL have parameter: step_width, 4, width of step input (1..width).
REQ-003 SHALL have port: clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: clr  input  1  synchronous clear, active high.
REQ-006 SHALL have port: load  input  1  synchronous load enable, active low.
REQ-007 SHALL have port: data  input  width  value loaded when load is low.
REQ-008 SHALL have port: cen  input  1  count enable, active high.
REQ-009 SHALL have port: up_dn  input  1  1 = count up, 0 = count down.
REQ-010 SHALL have port: step  input  step_width  unsigned increment/decrement per enabled cycle.
REQ-011 SHALL have port: modulus  input  width  upper bound M; legal count range 0..M.
REQ-012 SHALL have port: sat_mode  input  1  1 = saturate at bounds, 0 = wrap modulo M+1.
REQ-013 SHALL have port: count  output  width  registered counter value.
REQ-014 SHALL have port: tercnt  output  1  combinational terminal-count flag.
REQ-015 SHALL have port: wrap  output  1  registered one-cycle wrap-event pulse.
REQ-016 SHALL have port: sat_hit  output  1  registered one-cycle saturation-clip pulse.

Function
REQ-017 SHALL apply per-edge priority: clr > load (low) > cen > hold.
REQ-018 SHALL set count to 0 on clr; wrap and sat_hit 0 that cycle.
REQ-019 SHALL set count to data on load low, unchecked against M; wrap and sat_hit 0.
REQ-020 SHALL hold count when cen low, or when cen high and step = 0; flags 0.
REQ-021 SHALL clamp the effective step S to min(step, M+1), zero-extended to width.
REQ-022 SHALL compute all sums in width+1 bits, so M = all-ones gives a modulus of 2^width without loss.
REQ-023 Up, count <= M, count+S <= M: SHALL set next = count+S.
REQ-024 Up, count+S > M, wrap mode: SHALL set next = count+S-(M+1) and pulse wrap.
REQ-025 Up, count+S > M, saturate mode: SHALL set next = M and pulse sat_hit; a count already at M gives no pulse.
REQ-026 Down, S <= count <= M: SHALL set next = count-S.
REQ-027 Down, S > count, wrap mode: SHALL set next = count+(M+1)-S and pulse wrap.
REQ-028 Down, S > count, saturate mode: SHALL set next = 0 and pulse sat_hit; a count already at 0 gives no pulse.
REQ-029 Enabled up count with count > M (after load or a lowered M): SHALL give next = 0 with wrap (wrap mode) or next = M with sat_hit (saturate mode).
REQ-030 Enabled down count with count > M: SHALL give next = M in both modes, with no flag.
REQ-031 SHALL assert tercnt combinationally when (up_dn=1 and count=M) or (up_dn=0 and count=0), with no dependency on cen.
REQ-032 SHALL register wrap and sat_hit with the count update, so each is high exactly in the cycle after the causing edge.
REQ-033 SHALL never assert wrap and sat_hit together.
REQ-034 SHALL sample modulus, sat_mode, step and up_dn every cycle; a change takes effect on the next enabled edge with no pipeline state.
REQ-035 SHALL behave as the plain modular up/down counter when M = all-ones, step = 1 and sat_mode = 0.

Reset
REQ-036 SHALL force count = 0, wrap = 0 and sat_hit = 0 immediately while reset is low, independent of clk.
REQ-037 SHALL take the first update on the first rising clk edge after reset deasserts; no recovery cycles.
REQ-038 Reset asserted mid-count or mid-pulse SHALL abort the pulse; tercnt SHALL then reflect count = 0.

Verification
REQ-039 SHALL cover wrap-up: width=4, M=9, step=3, up, wrap mode from 0 -> 3,6,9,2; wrap high only in the cycle count=2.
REQ-040 SHALL cover saturate-down: M=9, step=4, down, sat_mode=1, load 6 -> 2,0,0; sat_hit one pulse at count=0, tercnt=1 from the first 0.
REQ-041 SHALL cover full-range modulus: M=15, step=1, up, wrap mode from 15 -> 0 with wrap pulse, checked against a 5-bit reference model.
REQ-042 SHALL cover priority: clr=1, load=0, cen=1 together -> count=0; then load=0 with data=12, cen=1 -> count=12.
REQ-043 SHALL cover out-of-range: M=9, load 13, up, sat_mode=0 -> 0 with wrap; reload 13, down -> 9, no flag.
REQ-044 SHALL cover async reset: reset pulsed low between clk edges while counting -> count=0 at once and flags low; the first edge after release counts from 0.
